// File: rtl/beep_gameover_seq.sv
// rtl/beep_gameover_seq.sv - game-over jingle sequencer: 8-note descending square-wave tune
module beep_gameover_seq #(
    parameter int TONE_UNIT   = 5000,
    parameter int NOTE_CYCLES = 15_000_000,
    parameter int GAP_CYCLES  = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] gamemode,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [2:0] note_idx,
    output logic       done
);

    localparam int DMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int TW   = $clog2(19 * TONE_UNIT);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gm_q, gm_d;
    logic [2:0]    note_idx_q, note_idx_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ph_q, ph_d;
    logic          beep_q, beep_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          in_over;
    logic          start;
    logic [TW-1:0] h_last;

    // Last tone-counter value of the current note's half-period.
    always_comb begin
        h_last = TW'(10 * TONE_UNIT - 1);
        case (note_idx_q)
            3'd0:    h_last = TW'(10 * TONE_UNIT - 1);
            3'd1:    h_last = TW'(11 * TONE_UNIT - 1);
            3'd2:    h_last = TW'(12 * TONE_UNIT - 1);
            3'd3:    h_last = TW'(13 * TONE_UNIT - 1);
            3'd4:    h_last = TW'(14 * TONE_UNIT - 1);
            3'd5:    h_last = TW'(15 * TONE_UNIT - 1);
            3'd6:    h_last = TW'(17 * TONE_UNIT - 1);
            default: h_last = TW'(19 * TONE_UNIT - 1);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gm_d       = gamemode;
        note_idx_d = note_idx_q;
        dcnt_d     = dcnt_q;
        tcnt_d     = tcnt_q;
        ph_d       = ph_q;
        done_d     = 1'b0;
        in_over    = (gamemode == 2'b11);
        start      = in_over && (gm_q != 2'b11);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = PLAY;
                    note_idx_d = 3'd0;
                    dcnt_d     = '0;
                    tcnt_d     = '0;
                    ph_d       = 1'b1;
                end
            end
            PLAY: begin
                if (tcnt_q == h_last) begin
                    tcnt_d = '0;
                    ph_d   = ~ph_q;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (dcnt_q == DW'(NOTE_CYCLES - 1)) begin
                    state_d = GAP;
                    dcnt_d  = '0;
                    ph_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            GAP: begin
                ph_d = 1'b0;
                if (dcnt_q == DW'(GAP_CYCLES - 1)) begin
                    dcnt_d = '0;
                    if (note_idx_q != 3'd7) begin
                        state_d    = PLAY;
                        note_idx_d = note_idx_q + 3'd1;
                        tcnt_d     = '0;
                        ph_d       = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: ;
        endcase

        // Leaving game-over overrides everything, including the final done pulse.
        if (state_q != IDLE && !in_over) begin
            state_d    = IDLE;
            note_idx_d = 3'd0;
            dcnt_d     = '0;
            tcnt_d     = '0;
            ph_d       = 1'b0;
            done_d     = 1'b0;
        end

        beep_d = (state_d == PLAY) && ph_d && !mute;
        busy_d = (state_d == PLAY) || (state_d == GAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gm_q       <= 2'b00;
            note_idx_q <= 3'd0;
            dcnt_q     <= '0;
            tcnt_q     <= '0;
            ph_q       <= 1'b0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gm_q       <= gm_d;
            note_idx_q <= note_idx_d;
            dcnt_q     <= dcnt_d;
            tcnt_q     <= tcnt_d;
            ph_q       <= ph_d;
            beep_q     <= beep_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign beep     = beep_q;
    assign busy     = busy_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_beep_gameover_seq.sv
// tb/tb_beep_gameover_seq.sv - self-checking bench for beep_gameover_seq against a cycle-index tune model
module tb_beep_gameover_seq;

    localparam int NOTE = 40;
    localparam int GAPC = 5;
    localparam int SLOT = NOTE + GAPC;
    localparam int TUNE = 8 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] gamemode;
    logic       mute;
    logic       beep;
    logic       busy;
    logic [2:0] note_idx;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;
    int rom [8]  = '{10, 11, 12, 13, 14, 15, 17, 19};

    beep_gameover_seq #(
        .TONE_UNIT  (1),
        .NOTE_CYCLES(NOTE),
        .GAP_CYCLES (GAPC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gamemode(gamemode),
        .mute    (mute),
        .beep    (beep),
        .busy    (busy),
        .note_idx(note_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".beep"}, {7'd0, beep}, 8'd0);
        chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
        chk({tag, ".note"}, {5'd0, note_idx}, 8'd0);
        chk({tag, ".done"}, {7'd0, done}, 8'd0);
    endtask

    // Expected outputs k cycles after the start edge, derived from the tune layout.
    function automatic void model(input int k, input bit m, output bit b, output bit bz,
                                  output bit d, output int n);
        int r;
        if (k < TUNE) begin
            n  = k / SLOT;
            r  = k % SLOT;
            bz = 1'b1;
            d  = 1'b0;
            b  = (r < NOTE) && (((r / rom[n]) % 2) == 0) && !m;
        end else begin
            n  = 7;
            bz = 1'b0;
            b  = 1'b0;
            d  = (k == TUNE);
        end
    endfunction

    // mode: 0 = mute only inside [mlo,mhi], 1 = random mute each cycle. abort_at < 0 disables abort.
    task automatic run_tune(input string tag, input int cycles, input int mode,
                            input int mlo, input int mhi, input int abort_at);
        bit b, bz, d, m;
        int n;
        for (int k = 0; k < cycles; k++) begin
            gamemode = (abort_at >= 0 && k >= abort_at) ? 2'b01 : 2'b11;
            m = (mode == 1) ? bit'($urandom_range(0, 1)) : (k >= mlo && k <= mhi);
            mute = m;
            @(posedge clk);
            #1;
            if (abort_at >= 0 && k >= abort_at) begin
                chk_all_zero($sformatf("%s.abort@%0d", tag, k));
            end else begin
                model(k, m, b, bz, d, n);
                chk($sformatf("%s.beep@%0d", tag, k), {7'd0, beep}, {7'd0, b});
                chk($sformatf("%s.busy@%0d", tag, k), {7'd0, busy}, {7'd0, bz});
                chk($sformatf("%s.done@%0d", tag, k), {7'd0, done}, {7'd0, d});
                chk($sformatf("%s.note@%0d", tag, k), {5'd0, note_idx}, 8'(n));
            end
        end
        mute = 1'b0;
    endtask

    task automatic idle_cycles(input int cycles);
        gamemode = 2'b00;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            chk_all_zero($sformatf("idle@%0d", k));
        end
    endtask

    initial begin
        int ab;
        rst_n    = 1'b0;
        gamemode = 2'b00;
        mute     = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        // Full tune held in game-over, then no replay.
        run_tune("full", TUNE + 5, 0, -1, -1, -1);
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("noreplay.beep@%0d", k), {7'd0, beep}, 8'd0);
            chk($sformatf("noreplay.busy@%0d", k), {7'd0, busy}, 8'd0);
            chk($sformatf("noreplay.done@%0d", k), {7'd0, done}, 8'd0);
        end

        // Re-entry with a mute window.
        idle_cycles(2);
        run_tune("mute", TUNE + 3, 0, 20, 60, -1);

        // Abort during note 2, then a random abort point.
        idle_cycles(2);
        run_tune("abort100", 105, 0, -1, -1, 100);
        idle_cycles(2);
        ab = $urandom_range(1, TUNE - 1);
        run_tune("abortrnd", ab + 4, 0, -1, -1, ab);

        // Random per-cycle mute across a whole tune.
        idle_cycles(2);
        run_tune("rndmute", TUNE + 3, 1, -1, -1, -1);

        // Asynchronous reset mid-tune with game-over still asserted on release.
        idle_cycles(2);
        run_tune("prereset", 150, 0, -1, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_tune("postreset", TUNE + 3, 0, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/beep_gameover_seq.md
# beep_gameover_seq

Melody sequencer for the end-of-game jingle. It detects entry into the game-over mode (`gamemode == 2'b11`) and plays a fixed 8-note descending tune on a square-wave `beep` line. It then holds silent until the mode is left. It sits directly upstream of the top-level beep mux, which forwards this block's `beep` to the buzzer pin while the game is over.

## Interface
Parameters:
- `TONE_UNIT`, default 5000: clock cycles per unit of the note ROM. A note's half-period is `ROM[i] * TONE_UNIT` cycles.
- `NOTE_CYCLES`, default 15_000_000: cycles each note sounds (≥1).
- `GAP_CYCLES`, default 2_000_000: silent cycles after each note (≥1). A value of 0 is not supported.

Ports:
- `clk` input 1: system clock. All logic is on `posedge clk`.
- `rst_n` input 1: asynchronous, active-low reset.
- `gamemode` input 2: game state. `2'b11` means game over.
- `mute` input 1: forces `beep` low. Sequencing continues unaffected.
- `beep` output 1: registered square-wave tone.
- `busy` output 1: high while the tune is playing (PLAY or GAP).
- `note_idx` output 3: index of the current note, 0..7.
- `done` output 1: one-cycle pulse when the tune completes.

## Operation
- Note ROM, half-period in units, indices 0..7: 10, 11, 12, 13, 14, 15, 17, 19. Index 0 has the highest pitch.
- `gm_q` is a registered copy of `gamemode`.
- A start event is the condition `gamemode == 2'b11 && gm_q != 2'b11`.
- FSM states: IDLE, PLAY, GAP, DONE.
  - IDLE: on a start event → PLAY, with `note_idx=0`, duration counter `dcnt=0`, tone counter `tcnt=0`, and tone phase `ph=1`.
  - PLAY:
    - `tcnt` counts 0..H-1, where H = `ROM[note_idx]*TONE_UNIT`. At H-1, `tcnt` wraps to 0 and `ph` toggles.
    - `dcnt` counts 0..NOTE_CYCLES-1. At the last count → GAP with `dcnt=0`.
  - GAP: `ph=0`; `dcnt` counts 0..GAP_CYCLES-1. At the last count:
    - if `note_idx<7` → PLAY with `note_idx+1`, `tcnt=0`, `ph=1`;
    - if `note_idx==7` → DONE, with `done=1` for one cycle.
  - DONE: silent. When `gamemode != 2'b11` → IDLE.
- Abort: in PLAY, GAP, or DONE, if `gamemode != 2'b11` the block goes to IDLE on the next edge. At the same edge `beep`, `busy` and `note_idx` go to 0; `done` is not pulsed.
- A start event only occurs on a new entry into mode 11. Staying in 11 after DONE never replays the tune.
- `beep` is registered: `beep <= (state==PLAY) & ph & ~mute`, using next-state values, so `beep` and the state change on the same edge.
- `busy` is registered: high in PLAY or GAP.
- Counter widths:
  - `dcnt` is sized by `$clog2(max(NOTE_CYCLES,GAP_CYCLES))`.
  - `tcnt` is sized by `$clog2(19*TONE_UNIT)`.
  - No overflow is possible.

## Timing
- Reset values: `beep=0`, `busy=0`, `note_idx=0`, `done=0`, state IDLE, `gm_q=2'b00`.
- If `gamemode==11` when `rst_n` deasserts, the first edge sees a start event and the tune plays.
- Start latency: `gamemode` becomes 11 before edge N → at edge N, `beep=1` and `busy=1`.
- Each note occupies NOTE_CYCLES cycles of PLAY followed by GAP_CYCLES cycles of GAP.
- Total tune length: 8*(NOTE_CYCLES+GAP_CYCLES) cycles from the start edge to the `done` edge.
- `done` is high for exactly the cycle after the final GAP count. `busy` falls on the same edge as `done` rises.
- `mute` affects `beep` at the next edge only. It does not change `note_idx`, `busy` or `done` timing.
- Reset asserted mid-tune: all outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: `TONE_UNIT=1`, `NOTE_CYCLES=40`, `GAP_CYCLES=5`.
- Reset, then `gamemode` 00→11:
  - `beep` goes high at the first edge.
  - Note 0 pattern: high 10 cycles, low 10, high 10, low 10, then 5 cycles low in GAP.
  - `note_idx` becomes 1 at cycle 45.
- Full run held at 11:
  - `done` pulses exactly at cycle 360 after start.
  - `busy` is high for cycles 0..359.
  - Note 7 plays toggles every 19 cycles.
  - No replay occurs within 1000 further cycles.
- Abort: `gamemode` 11→01 at cycle 100 (note 2) → `beep=0`, `busy=0`, `note_idx=0` at the next edge; no `done` pulse.
- Re-entry: after DONE, `gamemode` 11→00→11 → the tune restarts from note 0 with identical waveform.
- Mute: `mute=1` during cycles 20..60 → `beep=0` throughout that window. `note_idx` and `done` timing are unchanged (`done` still at 360).
- Reset mid-tune: `rst_n` low at cycle 150 → all outputs are 0 immediately. If `gamemode` is still 11 on release, the tune restarts from note 0 at the first edge.
